// File: rtl/i4003_loader.sv
// i4003_loader: serialises a parallel word MSB-first onto an i4003 shift chain
// and captures the previous chain contents from SERIAL_OUT as a readback word.
module i4003_loader #(
    parameter int CHAIN  = 2,
    parameter int CP_DIV = 2,
    parameter int BLANK  = 1
) (
    input  logic                CLK_i,
    input  logic                RESET_i,
    input  logic [10*CHAIN-1:0] DATA_i,
    input  logic                LOAD_i,
    output logic                READY_o,
    output logic                DONE_o,
    output logic [10*CHAIN-1:0] RDBK_o,
    output logic                CP_o,
    output logic                DATA_OUT_o,
    output logic                E_o,
    input  logic                SERIAL_IN_i
);

    localparam int N  = 10 * CHAIN;
    localparam int BW = $clog2(N);
    localparam int PW = $clog2(CP_DIV) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_FIN
    } state_t;

    state_t         r_state, w_state;
    logic [N-1:0]   r_buf, w_buf;
    logic [N-1:0]   r_rd, w_rd;
    logic [N-1:0]   r_rdbk, w_rdbk;
    logic [BW-1:0]  r_bit, w_bit;
    logic [PW-1:0]  r_ph, w_ph;
    logic           r_ready, w_ready;
    logic           r_done, w_done;
    logic           r_cp, w_cp;
    logic           r_dout, w_dout;
    logic           r_e, w_e;
    logic           w_ph_last;

    assign w_ph_last = (r_ph == PW'(CP_DIV - 1));

    always_ff @(posedge CLK_i) begin
        if (RESET_i) begin
            r_state <= S_IDLE;
            r_buf   <= '0;
            r_rd    <= '0;
            r_rdbk  <= '0;
            r_bit   <= '0;
            r_ph    <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_cp    <= 1'b0;
            r_dout  <= 1'b0;
            r_e     <= 1'b0;
        end else begin
            r_state <= w_state;
            r_buf   <= w_buf;
            r_rd    <= w_rd;
            r_rdbk  <= w_rdbk;
            r_bit   <= w_bit;
            r_ph    <= w_ph;
            r_ready <= w_ready;
            r_done  <= w_done;
            r_cp    <= w_cp;
            r_dout  <= w_dout;
            r_e     <= w_e;
        end
    end

    always_comb begin
        w_state = r_state;
        w_buf   = r_buf;
        w_rd    = r_rd;
        w_rdbk  = r_rdbk;
        w_bit   = r_bit;
        w_ph    = r_ph;
        w_ready = r_ready;
        w_done  = 1'b0;
        w_cp    = r_cp;
        w_dout  = r_dout;
        w_e     = r_e;
        unique case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (LOAD_i) begin
                    w_buf   = DATA_i;
                    w_bit   = '0;
                    w_ph    = '0;
                    w_ready = 1'b0;
                    w_cp    = 1'b0;
                    w_dout  = DATA_i[N-1];
                    w_state = S_LOW;
                    if (BLANK != 0) begin
                        w_e = 1'b0;
                    end
                end
            end
            S_LOW: begin
                if (w_ph_last) begin
                    // chain has not shifted yet, so this is the old bit N-1-k
                    w_rd    = {r_rd[N-2:0], SERIAL_IN_i};
                    w_ph    = '0;
                    w_cp    = 1'b1;
                    w_state = S_HIGH;
                end else begin
                    w_ph = r_ph + PW'(1);
                end
            end
            S_HIGH: begin
                if (w_ph_last) begin
                    w_ph = '0;
                    w_cp = 1'b0;
                    if (r_bit == BW'(N - 1)) begin
                        w_done  = 1'b1;
                        w_e     = 1'b1;
                        w_rdbk  = r_rd;
                        w_state = S_FIN;
                    end else begin
                        w_bit   = r_bit + BW'(1);
                        w_buf   = r_buf << 1;
                        w_dout  = r_buf[N-2];
                        w_state = S_LOW;
                    end
                end else begin
                    w_ph = r_ph + PW'(1);
                end
            end
            S_FIN: begin
                w_ready = 1'b1;
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign READY_o    = r_ready;
    assign DONE_o     = r_done;
    assign RDBK_o     = r_rdbk;
    assign CP_o       = r_cp;
    assign DATA_OUT_o = r_dout;
    assign E_o        = r_e;

endmodule

// File: tb/tb_i4003_loader.sv
// Directed bench for i4003_loader: two configurations, each driving a
// behavioural i4003 chain model, checked against hand-computed vectors.
module tb_i4003_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        load_a, ready_a, done_a, cp_a, dout_a, e_a, ser_a;
    logic [9:0]  data_a, rdbk_a;
    logic        load_b, ready_b, done_b, cp_b, dout_b, e_b, ser_b;
    logic [19:0] data_b, rdbk_b;

    i4003_loader #(.CHAIN(1), .CP_DIV(2), .BLANK(1)) u_a (
        .CLK_i(clk), .RESET_i(rst), .DATA_i(data_a), .LOAD_i(load_a),
        .READY_o(ready_a), .DONE_o(done_a), .RDBK_o(rdbk_a), .CP_o(cp_a),
        .DATA_OUT_o(dout_a), .E_o(e_a), .SERIAL_IN_i(ser_a)
    );

    i4003_loader #(.CHAIN(2), .CP_DIV(1), .BLANK(1)) u_b (
        .CLK_i(clk), .RESET_i(rst), .DATA_i(data_b), .LOAD_i(load_b),
        .READY_o(ready_b), .DONE_o(done_b), .RDBK_o(rdbk_b), .CP_o(cp_b),
        .DATA_OUT_o(dout_b), .E_o(e_b), .SERIAL_IN_i(ser_b)
    );

    // behavioural chains: chip c bit b at index 10*c+b, DATA_IN enters bit 0
    logic [9:0]  q_a = '0;
    logic [19:0] q_b = '0;
    always @(posedge cp_a) q_a <= {q_a[8:0], dout_a};
    always @(posedge cp_b) q_b <= {q_b[18:0], dout_b};
    assign ser_a = q_a[9];
    assign ser_b = q_b[19];

    logic sel;
    logic s_cp, s_ready, s_done, s_e;
    assign s_cp    = sel ? cp_b    : cp_a;
    assign s_ready = sel ? ready_b : ready_a;
    assign s_done  = sel ? done_b  : done_a;
    assign s_e     = sel ? e_b     : e_a;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start(input logic [19:0] d, input string nm);
        @(negedge clk);
        chk({nm, "_ready_pre"}, 32'(s_ready), 32'd1);
        if (sel) begin
            data_b = d;
            load_b = 1'b1;
        end else begin
            data_a = d[9:0];
            load_a = 1'b1;
        end
        @(negedge clk);
        load_a = 1'b0;
        load_b = 1'b0;
        chk({nm, "_ready_busy"}, 32'(s_ready), 32'd0);
    endtask

    task automatic finish_xfer(input string nm);
        int   n, dpc, off, edges, first, done_off;
        logic pcp, e_hi;
        n = sel ? 20 : 10;
        dpc = sel ? 1 : 2;
        off = 0;
        edges = 0;
        first = -1;
        done_off = -1;
        pcp = 1'b0;
        e_hi = 1'b0;
        while (off < 200) begin
            if (s_cp && !pcp) begin
                edges++;
                if (first < 0) first = off;
            end
            pcp = s_cp;
            if (s_done) begin
                done_off = off;
                break;
            end
            if (s_e) e_hi = 1'b1;
            @(negedge clk);
            off++;
        end
        chk({nm, "_edges"}, 32'(edges), 32'(n));
        chk({nm, "_first_cp"}, 32'(first), 32'(dpc));
        chk({nm, "_done_at"}, 32'(done_off), 32'(2 * n * dpc));
        chk({nm, "_e_blank"}, 32'(e_hi), 32'd0);
        chk({nm, "_e_done"}, 32'(s_e), 32'd1);
        @(negedge clk);
        chk({nm, "_ready_back"}, 32'(s_ready), 32'd1);
        chk({nm, "_done_pulse"}, 32'(s_done), 32'd0);
    endtask

    typedef struct {
        logic [19:0] d;
        logic [9:0]  q0;
        logic [9:0]  q1;
        logic [19:0] rb;
    } vec_t;

    vec_t va[4];
    vec_t vb[2];

    initial begin
        int   cnt, rises, guard;
        logic pcp;

        va[0] = '{20'h002A5, 10'h2A5, 10'h000, 20'h00000};
        va[1] = '{20'h000F0, 10'h0F0, 10'h000, 20'h002A5};
        va[2] = '{20'h00200, 10'h200, 10'h000, 20'h000F0};
        va[3] = '{20'h0015A, 10'h15A, 10'h000, 20'h00200};
        vb[0] = '{20'hABCDE, 10'h0DE, 10'h2AF, 20'h00000};
        vb[1] = '{20'h12345, 10'h345, 10'h048, 20'hABCDE};

        rst = 1'b1;
        load_a = 1'b0;
        load_b = 1'b0;
        data_a = '0;
        data_b = '0;
        sel = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_a", 32'(ready_a), 32'd1);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_rdbk_a", 32'(rdbk_a), 32'd0);
        chk("rst_cp_a", 32'(cp_a), 32'd0);
        chk("rst_dout_a", 32'(dout_a), 32'd0);
        chk("rst_e_a", 32'(e_a), 32'd0);
        chk("rst_ready_b", 32'(ready_b), 32'd1);
        chk("rst_rdbk_b", 32'(rdbk_b), 32'd0);
        chk("rst_e_b", 32'(e_b), 32'd0);

        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (cp_a || cp_b || !ready_a || e_a) cnt++;
        end
        chk("idle_quiet", 32'(cnt), 32'd0);

        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start(va[i].d, $sformatf("a%0d", i));
            finish_xfer($sformatf("a%0d", i));
            chk($sformatf("a%0d_q", i), 32'(q_a), 32'(va[i].q0));
            chk($sformatf("a%0d_rdbk", i), 32'(rdbk_a), 32'(va[i].rb));
        end

        sel = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start(vb[i].d, $sformatf("b%0d", i));
            finish_xfer($sformatf("b%0d", i));
            chk($sformatf("b%0d_chip0", i), 32'(q_b[9:0]), 32'(vb[i].q0));
            chk($sformatf("b%0d_chip1", i), 32'(q_b[19:10]), 32'(vb[i].q1));
            chk($sformatf("b%0d_rdbk", i), 32'(rdbk_b), 32'(vb[i].rb));
        end

        // back-to-back with LOAD_i held high
        sel = 1'b0;
        @(negedge clk);
        data_a = 10'h3FF;
        load_a = 1'b1;
        @(negedge clk);
        chk("b2b_busy1", 32'(ready_a), 32'd0);
        data_a = 10'h001;
        finish_xfer("b2b1");
        @(negedge clk);
        chk("b2b_accept2", 32'(ready_a), 32'd0);
        load_a = 1'b0;
        finish_xfer("b2b2");
        chk("b2b_rdbk", 32'(rdbk_a), 32'h3FF);
        chk("b2b_q", 32'(q_a), 32'h001);

        // LOAD_i pulse mid-transfer must be ignored
        start(20'h00155, "mid");
        repeat (6) @(negedge clk);
        data_a = 10'h2AA;
        load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (done_a) cnt++;
        end
        chk("mid_dones", 32'(cnt), 32'd1);
        chk("mid_q", 32'(q_a), 32'h155);
        chk("mid_rdbk", 32'(rdbk_a), 32'h001);
        chk("mid_ready", 32'(ready_a), 32'd1);

        // reset during bit 5
        start(20'h002A5, "rst5");
        rises = 0;
        guard = 0;
        pcp = 1'b0;
        while (!(rises == 5 && !cp_a) && guard < 100) begin
            if (cp_a && !pcp) rises++;
            pcp = cp_a;
            if (!(rises == 5 && !cp_a)) begin
                @(negedge clk);
                guard++;
            end
        end
        chk("rst5_reach", 32'(rises), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst5_cp", 32'(cp_a), 32'd0);
        chk("rst5_e", 32'(e_a), 32'd0);
        chk("rst5_ready", 32'(ready_a), 32'd1);
        chk("rst5_rdbk", 32'(rdbk_a), 32'd0);
        cnt = 0;
        repeat (60) begin
            if (done_a || cp_a) cnt++;
            @(negedge clk);
        end
        chk("rst5_no_done", 32'(cnt), 32'd0);
        start(20'h0033C, "after");
        finish_xfer("after");
        chk("after_q", 32'(q_a), 32'h33C);

        // reset and load together: reset wins
        @(negedge clk);
        rst = 1'b1;
        data_a = 10'h3FF;
        load_a = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load_a = 1'b0;
        cnt = 0;
        repeat (10) begin
            if (cp_a || !ready_a) cnt++;
            @(negedge clk);
        end
        chk("rst_load_ignored", 32'(cnt), 32'd0);
        chk("rst_load_q", 32'(q_a), 32'h33C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i4003_loader.md
# i4003_loader

Upstream driver for a daisy-chain of i4003 10-bit shift registers. It accepts a parallel word over a valid/ready handshake and serialises it MSB-first onto the chain's DATA_IN/CP pins, with a programmable CP pulse width. It gates the chain's output-enable around the transfer and captures the bits returned on the chain's SERIAL_OUT as a readback of the previous contents. It sits between the system-side I/O port logic and the external/behavioural i4003 chain.

## Interface
- CHAIN, 2: number of cascaded i4003 devices; N = 10*CHAIN bits total (CHAIN >= 1).
- CP_DIV, 2: CLK_i cycles per CP phase; one bit = 2*CP_DIV cycles (CP_DIV >= 1).
- BLANK, 1: 1 = hold E_o low while shifting; 0 = E_o stays high once the first load has completed.

- CLK_i  in  1  system clock; all logic on rising edge.
- RESET_i  in  1  synchronous, active-high reset.
- DATA_i  in  N  word to load; after load, chip c Q[b] = DATA_i[10*c+b] (chip 0 is nearest the loader).
- LOAD_i  in  1  request; word accepted on an edge where LOAD_i & READY_o.
- READY_o  out  1  loader idle, can accept.
- DONE_o  out  1  one-cycle pulse when a transfer completes.
- RDBK_o  out  N  chain contents before the last transfer, same bit mapping as DATA_i.
- CP_o  out  1  to chain CP_i; the chain samples DATA_IN on the CP rising edge.
- DATA_OUT_o  out  1  to chip 0 DATA_IN_i.
- E_o  out  1  to all chips' E_i.
- SERIAL_IN_i  in  1  from the last chip's SERIAL_OUT_o.

## Operation
- States: IDLE, LOW (CP_o=0, bit presented), HIGH (CP_o=1), FIN.
- IDLE: READY_o=1. On accept:
  - latch DATA_i into the shift buffer;
  - clear the bit counter;
  - go to LOW;
  - drop READY_o;
  - if BLANK, drop E_o.
- LOW: DATA_OUT_o = buffer[N-1-k] for bit k (DATA_i[N-1] first, DATA_i[0] last). Lasts CP_DIV cycles.
  - On its last cycle, sample SERIAL_IN_i into the readback shifter: shift left, insert at LSB.
- HIGH: CP_o=1 for CP_DIV cycles; DATA_OUT_o held stable.
  - Exit to LOW with k+1, or to FIN after bit N-1.
  - DATA_OUT_o changes only on the cycle CP_o falls.
- FIN (1 cycle):
  - CP_o=0;
  - DONE_o=1;
  - RDBK_o <= readback shifter;
  - E_o=1;
  - READY_o=1 from the next cycle (state -> IDLE).
- LOAD_i while READY_o=0 is ignored; the request is not queued.
- Bit counter width is clog2(N); phase counter width is clog2(CP_DIV)+1. No wrap beyond N.
- All outputs are registered.

## Timing
- Reset values: READY_o=1, DONE_o=0, RDBK_o=0, CP_o=0, DATA_OUT_o=0, E_o=0. State = IDLE.
- Accept at edge t:
  - cycle t+1: LOW with bit N-1 on DATA_OUT_o;
  - bit k rising edge of CP_o: t+1+(2k+1)*CP_DIV;
  - falling edge: t+1+(2k+2)*CP_DIV.
- DONE_o and E_o=1 in cycle t+1+2*N*CP_DIV; READY_o=1 one cycle later; next accept is possible at that edge.
- Each bit is set up CP_DIV cycles before the CP rising edge and held CP_DIV cycles after it.
- E_o stays 0 after reset until the first DONE.
- RESET_i asserted mid-transfer:
  - next cycle all outputs return to their reset values;
  - no DONE_o pulse;
  - RDBK_o is cleared;
  - chain contents are undefined.
- RESET_i and LOAD_i in the same cycle: reset wins; the word is not accepted.

## Test plan
- Reset then idle (CHAIN=1, CP_DIV=2): READY_o=1, CP_o=0, E_o=0, RDBK_o=0 and no CP_o activity for 50 cycles.
- Load 10'h2A5 on a behavioural i4003 model:
  - exactly 10 CP_o rising edges, first at t+3;
  - DONE_o at t+41;
  - model Q = 10'h2A5;
  - E_o rises with DONE_o.
- Back-to-back loads 10'h3FF then 10'h001 with LOAD_i held high:
  - second accept on the cycle READY_o returns;
  - after the second DONE, RDBK_o = 10'h3FF and model Q = 10'h001.
- CHAIN=2, CP_DIV=1, DATA_i=20'hABCDE:
  - chip 0 Q = 10'h0DE and chip 1 Q = 10'h2AF;
  - DONE_o at t+41.
- LOAD_i pulsed with a different word mid-transfer: ignored; the original word lands and only one DONE_o occurs.
- RESET_i at bit 5 of a transfer: CP_o=0, E_o=0 and READY_o=1 next cycle; no DONE_o; a new load completes normally afterwards.
